trap_sequencer: RTL and testbench

//  Multi-cycle trap/return sequencer for the RV32IM core. Arbitrates the synchronous exception

---
 rtl/trap_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_trap_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : trap_sequencer                                               |
// | Description : Multi-cycle trap entry / MRET return sequencer for an RV32IM |
// |               core. Arbitrates the synchronous exception against machine   |
// |               interrupts, drains the pipeline, issues one CSR trap-entry   |
// |               write and one PC redirect, and sequences MRET.               |
// | Optional    : define TRAP_SEQUENCER_NMI_EN to add the nmi_i input and a    |
// |               non-maskable interrupt path.                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// Ports
//   clk               core clock
//   reset             synchronous, active-low reset
//   nmi_i             level NMI request (TRAP_SEQUENCER_NMI_EN only)
//   exc_valid_i       synchronous exception from execute
//   exc_cause_i       exception code
//   exc_pc_i          PC of faulting instruction
//   exc_tval_i        trap value
//   mret_i            MRET in execute
//   mstatus_mie_i     global machine interrupt enable
//   mie_i / mip_i     interrupt enable / pending CSRs
//   mtvec_i           [31:2] base, [1:0] mode (1 = vectored)
//   mepc_i            return address for MRET
//   pipe_pc_i         PC of oldest unretired instruction (interrupt mepc)
//   pipe_empty_i      pipeline drained
//   flush_o           kill all in-flight instructions
//   stall_fetch_o     hold fetch
//   busy_o            sequencer not idle
//   redirect_valid_o  load redirect_pc_o into PC (1-cycle pulse)
//   redirect_pc_o     new PC
//   csr_we_o          trap-entry CSR write strobe (1-cycle pulse)
//   mepc_o/mcause_o/mtval_o  trap-entry CSR write data
//   mret_restore_o    MIE<=MPIE, MPIE<=1 strobe (1-cycle pulse)
//
// Every output is a register loaded from a decode of the state the sequencer
// occupied during the previous cycle, so each state's effect appears on the
// pins one cycle after the state itself.

module trap_sequencer #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          DRAIN_TIMEOUT = 8,
  parameter logic [31:0] NMI_VECTOR    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
`ifdef TRAP_SEQUENCER_NMI_EN
  input  logic        nmi_i,
`endif
  input  logic        exc_valid_i,
  input  logic [4:0]  exc_cause_i,
  input  logic [31:0] exc_pc_i,
  input  logic [31:0] exc_tval_i,
  input  logic        mret_i,
  input  logic        mstatus_mie_i,
  input  logic [31:0] mie_i,
  input  logic [31:0] mip_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  input  logic [31:0] pipe_pc_i,
  input  logic        pipe_empty_i,
  output logic        flush_o,
  output logic        stall_fetch_o,
  output logic        busy_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic        csr_we_o,
  output logic [31:0] mepc_o,
  output logic [31:0] mcause_o,
  output logic [31:0] mtval_o,
  output logic        mret_restore_o
);

  // Counter holds 0..DRAIN_TIMEOUT-1, never narrower than 3 bits.
  localparam int CNT_W = ($clog2(DRAIN_TIMEOUT) < 3) ? 3 : $clog2(DRAIN_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_BOOT     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_DRAIN    = 3'd2,
    ST_WRITE    = 3'd3,
    ST_REDIRECT = 3'd4,
    ST_RET      = 3'd5
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] drain_cnt;
  logic             drain_done;

  // Latched trap context
  logic             trap_irq;     // latched trap is an interrupt (vectoring allowed)
  logic [31:0]      ret_pc;       // MRET target, word aligned at capture

  // Interrupt arbitration
  logic [2:0]       irq_pend;     // {MTI, MSI, MEI} qualified by enables
  logic             irq_any;
  logic [4:0]       irq_code;

  logic             take_exc;
  logic             take_irq;
  logic             take_mret;
`ifdef TRAP_SEQUENCER_NMI_EN
  logic             take_nmi;
  logic             nmi_r;
`else
  logic             unused_nmi_vector;
  assign unused_nmi_vector = ^NMI_VECTOR;
`endif

  // Next-cycle output values
  logic             flush_nxt;
  logic             stall_nxt;
  logic             busy_nxt;
  logic             redirect_valid_nxt;
  logic [31:0]      redirect_pc_nxt;
  logic             csr_we_nxt;
  logic             mret_restore_nxt;
  logic [31:0]      trap_target;

  // Only bits 3/7/11 of mie/mip and the word part of mepc are consumed.
  logic             unused_bits;
  assign unused_bits = ^{mepc_i[1:0], mie_i, mip_i};

  assign drain_done = pipe_empty_i || (drain_cnt == CNT_LAST);

  // ---------------------------------------------------------------------------
  // Interrupt selection: MEI(11) > MSI(3) > MTI(7)
  // ---------------------------------------------------------------------------
  always_comb begin
    irq_pend[0] = mstatus_mie_i & mie_i[11] & mip_i[11];
    irq_pend[1] = mstatus_mie_i & mie_i[3]  & mip_i[3];
    irq_pend[2] = mstatus_mie_i & mie_i[7]  & mip_i[7];
    irq_any     = |irq_pend;
    irq_code    = 5'd0;
    if (irq_pend[0]) begin
      irq_code = 5'd11;
    end else if (irq_pend[1]) begin
      irq_code = 5'd3;
    end else if (irq_pend[2]) begin
      irq_code = 5'd7;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Requests arriving outside IDLE are simply not looked at;
  // the pipeline flush discards the instructions that raised them.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    take_exc  = 1'b0;
    take_irq  = 1'b0;
    take_mret = 1'b0;
`ifdef TRAP_SEQUENCER_NMI_EN
    take_nmi  = 1'b0;
`endif
    case (state)
      ST_BOOT: begin
        state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
`ifdef TRAP_SEQUENCER_NMI_EN
        if (nmi_i) begin
          take_nmi  = 1'b1;
          state_nxt = ST_DRAIN;
        end else
`endif
        if (exc_valid_i) begin
          take_exc  = 1'b1;
          state_nxt = ST_DRAIN;
        end else if (mret_i) begin
          take_mret = 1'b1;
          state_nxt = ST_RET;
        end else if (irq_any) begin
          take_irq  = 1'b1;
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_done) begin
          state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        state_nxt = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        state_nxt = ST_IDLE;
      end
      ST_RET: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Trap vector. Only interrupts are vectored; the offset is 4*code and the
  // add wraps modulo 2^32.
  // ---------------------------------------------------------------------------
  always_comb begin
    trap_target = {mtvec_i[31:2], 2'b00};
    if ((mtvec_i[1:0] == 2'b01) && trap_irq) begin
      trap_target = {mtvec_i[31:2], 2'b00} + {25'd0, mcause_o[4:0], 2'b00};
    end
`ifdef TRAP_SEQUENCER_NMI_EN
    if (nmi_r) begin
      trap_target = NMI_VECTOR;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Output decode of the current state, loaded into the output registers
  // ---------------------------------------------------------------------------
  always_comb begin
    flush_nxt          = ((state == ST_DRAIN) && (drain_cnt == '0)) || (state == ST_RET);
    stall_nxt          = (state == ST_DRAIN) || (state == ST_WRITE) || (state == ST_REDIRECT);
    busy_nxt           = (state != ST_IDLE);
    redirect_valid_nxt = (state == ST_BOOT) || (state == ST_REDIRECT) || (state == ST_RET);
    csr_we_nxt         = (state == ST_WRITE);
    mret_restore_nxt   = (state == ST_RET);
    redirect_pc_nxt    = redirect_pc_o;
    case (state)
      ST_BOOT:     redirect_pc_nxt = RESET_PC;
      ST_REDIRECT: redirect_pc_nxt = trap_target;
      ST_RET:      redirect_pc_nxt = ret_pc;
      default:     redirect_pc_nxt = redirect_pc_o;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, counter, trap context and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= ST_BOOT;
      drain_cnt        <= '0;
      trap_irq         <= 1'b0;
      ret_pc           <= 32'd0;
      flush_o          <= 1'b0;
      stall_fetch_o    <= 1'b0;
      busy_o           <= 1'b0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= RESET_PC;
      csr_we_o         <= 1'b0;
      mepc_o           <= 32'd0;
      mcause_o         <= 32'd0;
      mtval_o          <= 32'd0;
      mret_restore_o   <= 1'b0;
`ifdef TRAP_SEQUENCER_NMI_EN
      nmi_r            <= 1'b0;
`endif
    end else begin
      state <= state_nxt;

      // Counts DRAIN cycles; zero on entry to DRAIN
      if ((state == ST_DRAIN) && !drain_done) begin
        drain_cnt <= drain_cnt + 1'b1;
      end else begin
        drain_cnt <= '0;
      end

      if (take_exc) begin
        mcause_o <= {27'd0, exc_cause_i};
        mepc_o   <= exc_pc_i;
        mtval_o  <= exc_tval_i;
        trap_irq <= 1'b0;
`ifdef TRAP_SEQUENCER_NMI_EN
        nmi_r    <= 1'b0;
`endif
      end else if (take_irq) begin
        mcause_o <= {1'b1, 26'd0, irq_code};
        mepc_o   <= pipe_pc_i;
        mtval_o  <= 32'd0;
        trap_irq <= 1'b1;
`ifdef TRAP_SEQUENCER_NMI_EN
        nmi_r    <= 1'b0;
`endif
      end
`ifdef TRAP_SEQUENCER_NMI_EN
      if (take_nmi) begin
        mcause_o <= 32'h8000_0000;
        mepc_o   <= pipe_pc_i;
        mtval_o  <= 32'd0;
        trap_irq <= 1'b0;
        nmi_r    <= 1'b1;
      end
`endif

      if (take_mret) begin
        ret_pc <= {mepc_i[31:2], 2'b00};
      end

      flush_o          <= flush_nxt;
      stall_fetch_o    <= stall_nxt;
      busy_o           <= busy_nxt;
      redirect_valid_o <= redirect_valid_nxt;
      redirect_pc_o    <= redirect_pc_nxt;
      csr_we_o         <= csr_we_nxt;
      mret_restore_o   <= mret_restore_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_trap_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_trap_sequencer                                            |
// | Description : Scoreboard bench for trap_sequencer. Stimulus pushes the     |
// |               expected flush / CSR-write / redirect events with their      |
// |               cycle numbers; a monitor pops and compares as the DUT emits. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_trap_sequencer;

  localparam int K_REDIR = 0;
  localparam int K_CSR   = 1;
  localparam int K_FLUSH = 2;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        restore;
  } ev_t;

  ev_t exp_q[$];

  logic        clk = 1'b0;
  logic        reset = 1'b0;
`ifdef TRAP_SEQUENCER_NMI_EN
  logic        nmi = 1'b0;
`endif
  logic        exc_valid = 1'b0;
  logic [4:0]  exc_cause = '0;
  logic [31:0] exc_pc = '0;
  logic [31:0] exc_tval = '0;
  logic        mret = 1'b0;
  logic        mstatus_mie = 1'b0;
  logic [31:0] mie = '0;
  logic [31:0] mip = '0;
  logic [31:0] mtvec = 32'h200;
  logic [31:0] mepc = '0;
  logic [31:0] pipe_pc = '0;
  logic        pipe_empty = 1'b1;

  logic        flush_o, stall_fetch_o, busy_o, redirect_valid_o, csr_we_o, mret_restore_o;
  logic [31:0] redirect_pc_o, mepc_o, mcause_o, mtval_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  trap_sequencer #(
    .RESET_PC      (32'h100),
    .DRAIN_TIMEOUT (8),
    .NMI_VECTOR    (32'h0)
  ) dut (
    .clk              (clk),
    .reset            (reset),
`ifdef TRAP_SEQUENCER_NMI_EN
    .nmi_i            (nmi),
`endif
    .exc_valid_i      (exc_valid),
    .exc_cause_i      (exc_cause),
    .exc_pc_i         (exc_pc),
    .exc_tval_i       (exc_tval),
    .mret_i           (mret),
    .mstatus_mie_i    (mstatus_mie),
    .mie_i            (mie),
    .mip_i            (mip),
    .mtvec_i          (mtvec),
    .mepc_i           (mepc),
    .pipe_pc_i        (pipe_pc),
    .pipe_empty_i     (pipe_empty),
    .flush_o          (flush_o),
    .stall_fetch_o    (stall_fetch_o),
    .busy_o           (busy_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .csr_we_o         (csr_we_o),
    .mepc_o           (mepc_o),
    .mcause_o         (mcause_o),
    .mtval_o          (mtval_o),
    .mret_restore_o   (mret_restore_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string nm, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=%h required=no event (cycle %0d)", nm, act, cyc);
  endtask

  task automatic push(input int kind, input int c, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] cc, input logic restore);
    ev_t e;
    e.kind = kind; e.cyc = c; e.a = a; e.b = b; e.c = cc; e.restore = restore;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: compares every DUT event against the head of the scoreboard
  initial begin : monitor
    ev_t e;
    forever begin
      @(negedge clk);
      if (redirect_valid_o) begin
        if (exp_q.size() == 0) begin
          unexpected("unexpected_redirect", redirect_pc_o);
        end else begin
          e = exp_q.pop_front();
          chk("redirect_kind", K_REDIR, e.kind);
          chk("redirect_cycle", cyc, e.cyc);
          chk("redirect_pc", redirect_pc_o, e.a);
          chk("redirect_mret_restore", {31'd0, mret_restore_o}, {31'd0, e.restore});
          chk("redirect_flush", {31'd0, flush_o}, {31'd0, e.restore});
        end
      end else if (csr_we_o) begin
        if (exp_q.size() == 0) begin
          unexpected("unexpected_csr_we", mcause_o);
        end else begin
          e = exp_q.pop_front();
          chk("csr_kind", K_CSR, e.kind);
          chk("csr_cycle", cyc, e.cyc);
          chk("csr_mcause", mcause_o, e.a);
          chk("csr_mepc", mepc_o, e.b);
          chk("csr_mtval", mtval_o, e.c);
        end
      end else if (flush_o) begin
        if (exp_q.size() == 0) begin
          unexpected("unexpected_flush", 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("flush_kind", K_FLUSH, e.kind);
          chk("flush_cycle", cyc, e.cyc);
        end
      end
      if (mret_restore_o && !redirect_valid_o) begin
        unexpected("stray_mret_restore", 32'd1);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int k;
    // Reset held for two cycles
    tick(2);
    chk("rst_redirect_pc", redirect_pc_o, 32'h100);
    chk("rst_redirect_valid", {31'd0, redirect_valid_o}, 32'd0);
    chk("rst_flush", {31'd0, flush_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_fetch_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_csr_we", {31'd0, csr_we_o}, 32'd0);
    chk("rst_mcause", mcause_o, 32'd0);
    chk("rst_mepc", mepc_o, 32'd0);
    chk("rst_mtval", mtval_o, 32'd0);

    // Boot redirect on the first edge with reset released
    reset = 1'b1;
    k = cyc;
    push(K_REDIR, k + 1, 32'h100, 0, 0, 1'b0);
    tick(3);
    chk("boot_idle_busy", {31'd0, busy_o}, 32'd0);

    // Exception, pipeline already empty: minimum latency
    k = cyc;
    exc_valid = 1'b1; exc_cause = 5'd2; exc_pc = 32'h40; exc_tval = 32'hDEAD;
    push(K_FLUSH, k + 2, 0, 0, 0, 1'b0);
    push(K_CSR,   k + 3, 32'h2, 32'h40, 32'hDEAD, 1'b0);
    push(K_REDIR, k + 4, 32'h200, 0, 0, 1'b0);
    tick(1); exc_valid = 1'b0;
    tick(1);
    chk("exc_stall_in_drain", {31'd0, stall_fetch_o}, 32'd1);
    chk("exc_busy_in_drain", {31'd0, busy_o}, 32'd1);
    tick(4);
    chk("exc_stall_released", {31'd0, stall_fetch_o}, 32'd0);

    // Vectored interrupts: MEI beats MTI
    mtvec = 32'h201; mie = 32'h880; mip = 32'h880; mstatus_mie = 1'b1; pipe_pc = 32'h300;
    k = cyc;
    push(K_FLUSH, k + 2, 0, 0, 0, 1'b0);
    push(K_CSR,   k + 3, 32'h8000_000B, 32'h300, 32'h0, 1'b0);
    push(K_REDIR, k + 4, 32'h22C, 0, 0, 1'b0);
    tick(1); mip = 32'h0;
    tick(5);

    // MSI beats MTI
    mie = 32'h88; mip = 32'h88; pipe_pc = 32'h404;
    k = cyc;
    push(K_FLUSH, k + 2, 0, 0, 0, 1'b0);
    push(K_CSR,   k + 3, 32'h8000_0003, 32'h404, 32'h0, 1'b0);
    push(K_REDIR, k + 4, 32'h20C, 0, 0, 1'b0);
    tick(1); mip = 32'h0;
    tick(5);

    // Global MIE clear masks everything
    mstatus_mie = 1'b0; mie = 32'h880; mip = 32'h880;
    tick(6);
    chk("mie_off_busy", {31'd0, busy_o}, 32'd0);
    mip = 32'h0; mstatus_mie = 1'b1;
    tick(1);

    // Exception + MRET + interrupt together: exception only, base vector
    exc_valid = 1'b1; exc_cause = 5'd5; exc_pc = 32'h44; exc_tval = 32'h1234;
    mret = 1'b1; mepc = 32'h87; mip = 32'h800;
    k = cyc;
    push(K_FLUSH, k + 2, 0, 0, 0, 1'b0);
    push(K_CSR,   k + 3, 32'h5, 32'h44, 32'h1234, 1'b0);
    push(K_REDIR, k + 4, 32'h200, 0, 0, 1'b0);
    tick(1); exc_valid = 1'b0; mret = 1'b0; mip = 32'h0;
    tick(5);

    // Drain timeout: 8 DRAIN cycles before WRITE
    pipe_empty = 1'b0;
    exc_valid = 1'b1; exc_cause = 5'd13; exc_pc = 32'h80; exc_tval = 32'h55;
    k = cyc;
    push(K_FLUSH, k + 2, 0, 0, 0, 1'b0);
    push(K_CSR,   k + 10, 32'hD, 32'h80, 32'h55, 1'b0);
    push(K_REDIR, k + 11, 32'h200, 0, 0, 1'b0);
    tick(1); exc_valid = 1'b0;
    tick(13);
    pipe_empty = 1'b1;

    // MRET: restore + flush + redirect to word-aligned mepc
    mepc = 32'h87; mret = 1'b1;
    k = cyc;
    push(K_REDIR, k + 2, 32'h84, 0, 0, 1'b1);
    tick(1); mret = 1'b0;
    tick(4);

    // Reset in the middle of DRAIN discards the trap
    pipe_empty = 1'b0;
    exc_valid = 1'b1; exc_cause = 5'd1; exc_pc = 32'h50; exc_tval = 32'h7;
    k = cyc;
    push(K_FLUSH, k + 2, 0, 0, 0, 1'b0);
    tick(1); exc_valid = 1'b0;
    tick(1); reset = 1'b0;
    tick(1);
    chk("midrst_csr_we", {31'd0, csr_we_o}, 32'd0);
    chk("midrst_busy", {31'd0, busy_o}, 32'd0);
    chk("midrst_redirect_pc", redirect_pc_o, 32'h100);
    chk("midrst_mcause", mcause_o, 32'd0);
    reset = 1'b1;
    push(K_REDIR, cyc + 1, 32'h100, 0, 0, 1'b0);
    tick(12);
    pipe_empty = 1'b1;
    tick(3);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
